instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 117 +++++++++++
 tb/tb_instr_fetch_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues in-order instruction memory requests, tags them with their PC,
// buffers responses in a 2-entry FIFO and supports redirects that drop in-flight responses.
module instr_fetch_unit #(
  parameter int unsigned            ISIZE    = 19,
  parameter int unsigned            ASIZE    = 8,
  parameter logic [ASIZE-1:0]       RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [ASIZE-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [ISIZE-1:0] imem_rdata,
  input  logic             redirect,
  input  logic [ASIZE-1:0] redirect_pc,
  input  logic             id_stall,
  output logic [ISIZE-1:0] inst_out,
  output logic [ASIZE-1:0] inst_pc,
  output logic             inst_valid
);

  logic [ASIZE-1:0] pc_q, pc_d;
  logic [ISIZE-1:0] fifo_inst_q [2];
  logic [ASIZE-1:0] fifo_pc_q [2];
  logic             fifo_rd_q, fifo_rd_d;
  logic             fifo_wr_q, fifo_wr_d;
  logic [1:0]       fifo_cnt_q, fifo_cnt_d;
  logic [1:0]       outst_q, outst_d;
  logic [1:0]       discard_q, discard_d;
  logic [ASIZE-1:0] pcq_q [2];
  logic             pcq_rd_q, pcq_wr_q;

  logic rsp, grant, push, pop, drop;

  // A response with nothing outstanding is illegal and ignored.
  assign rsp   = imem_rvalid && (outst_q != 2'd0);
  // Slot reservation: every outstanding request is guaranteed a FIFO entry.
  assign imem_req  = rst_n && !redirect &&
                     (({1'b0, outst_q} + {1'b0, fifo_cnt_q}) < 3'd2);
  assign imem_addr = pc_q;
  assign grant = imem_req && imem_gnt;
  assign push  = rsp && !redirect && (discard_q == 2'd0);
  assign drop  = rsp && !redirect && (discard_q != 2'd0);
  assign pop   = inst_valid && !id_stall && !redirect;

  assign inst_valid = (fifo_cnt_q != 2'd0);
  assign inst_out   = fifo_inst_q[fifo_rd_q];
  assign inst_pc    = fifo_pc_q[fifo_rd_q];

  always_comb begin
    pc_d       = pc_q;
    outst_d    = outst_q;
    discard_d  = discard_q;
    fifo_cnt_d = fifo_cnt_q;
    fifo_rd_d  = fifo_rd_q;
    fifo_wr_d  = fifo_wr_q;
    if (redirect) begin
      // Everything still in flight (minus this cycle's response) must be thrown away.
      pc_d       = redirect_pc;
      outst_d    = outst_q - {1'b0, rsp};
      discard_d  = outst_q - {1'b0, rsp};
      fifo_cnt_d = 2'd0;
      fifo_rd_d  = 1'b0;
      fifo_wr_d  = 1'b0;
    end else begin
      if (grant) begin
        pc_d = pc_q + ASIZE'(1);
      end
      outst_d = outst_q + {1'b0, grant} - {1'b0, rsp};
      if (drop) begin
        discard_d = discard_q - 2'd1;
      end
      fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
      fifo_wr_d  = fifo_wr_q ^ push;
      fifo_rd_d  = fifo_rd_q ^ pop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      outst_q    <= 2'd0;
      discard_q  <= 2'd0;
      fifo_cnt_q <= 2'd0;
      fifo_rd_q  <= 1'b0;
      fifo_wr_q  <= 1'b0;
      pcq_rd_q   <= 1'b0;
      pcq_wr_q   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_inst_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
        pcq_q[i]       <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      fifo_cnt_q <= fifo_cnt_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_wr_q  <= fifo_wr_d;
      if (push) begin
        fifo_inst_q[fifo_wr_q] <= imem_rdata;
        fifo_pc_q[fifo_wr_q]   <= pcq_q[pcq_rd_q];
      end
      // The PC queue tracks every accepted request, including ones a redirect will discard.
      if (grant) begin
        pcq_q[pcq_wr_q] <= pc_q;
        pcq_wr_q        <= ~pcq_wr_q;
      end
      if (rsp) begin
        pcq_rd_q <= ~pcq_rd_q;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a cycle vector table for the basic stream plus
// hand-written sequences for stall, redirect, PC wrap and mid-stream reset.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [18:0] imem_rdata;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        id_stall;
  logic [18:0] inst_out;
  logic [7:0]  inst_pc;
  logic        inst_valid;

  int errors = 0;
  int checks = 0;

  instr_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_stall    (id_stall),
    .inst_out    (inst_out),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        gnt;
    logic        rv;
    logic [18:0] rd;
    logic        req_e;
    logic [7:0]  addr_e;
    logic        valid_e;
    logic        chk_inst;
    logic [7:0]  ipc_e;
    logic [18:0] iout_e;
  } vec_t;

  vec_t vecs [7];

  function automatic vec_t mk(logic g, logic r, logic [18:0] d, logic req, logic [7:0] a,
                              logic v, logic ci, logic [7:0] ip, logic [18:0] io);
    vec_t t;
    t.gnt = g; t.rv = r; t.rd = d; t.req_e = req; t.addr_e = a;
    t.valid_e = v; t.chk_inst = ci; t.ipc_e = ip; t.iout_e = io;
    return t;
  endfunction

  function automatic logic [18:0] f(logic [7:0] pc);
    return {pc ^ 8'hA5, 3'b101, pc};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic g, input logic rv, input logic [18:0] rd, input logic st,
                        input logic rdr, input logic [7:0] rpc);
    @(negedge clk);
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
    id_stall = st; redirect = rdr; redirect_pc = rpc;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    id_stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Memory responder for free-running streams: one-cycle response latency, gnt always 1.
  logic       pend_v;
  logic [7:0] pend_a;
  logic [7:0] exp_pc;
  int         consumed;

  task automatic stream_cycle(input logic st);
    set_in(1'b1, pend_v, pend_v ? f(pend_a) : 19'h0, st, 1'b0, 8'h00);
    if (inst_valid && !st) begin
      chk("stream_pc", {24'h0, inst_pc}, {24'h0, exp_pc});
      chk("stream_data", {13'h0, inst_out}, {13'h0, f(exp_pc)});
      exp_pc++;
      consumed++;
    end
    pend_v = imem_req;
    pend_a = imem_addr;
  endtask

  logic [7:0]  hold_pc;
  logic [18:0] hold_out;

  initial begin
    vecs[0] = mk(1'b1, 1'b0, 19'h00000, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 19'h00000);
    vecs[1] = mk(1'b1, 1'b1, 19'h39807, 1'b1, 8'h01, 1'b0, 1'b1, 8'h00, 19'h00000);
    vecs[2] = mk(1'b1, 1'b1, 19'h39806, 1'b0, 8'h02, 1'b1, 1'b1, 8'h00, 19'h39807);
    vecs[3] = mk(1'b1, 1'b0, 19'h00000, 1'b1, 8'h02, 1'b1, 1'b1, 8'h01, 19'h39806);
    vecs[4] = mk(1'b1, 1'b1, 19'h39805, 1'b1, 8'h03, 1'b0, 1'b0, 8'h00, 19'h00000);
    vecs[5] = mk(1'b1, 1'b1, 19'h39804, 1'b0, 8'h04, 1'b1, 1'b1, 8'h02, 19'h39805);
    vecs[6] = mk(1'b1, 1'b0, 19'h00000, 1'b1, 8'h04, 1'b1, 1'b1, 8'h03, 19'h39804);

    // Reset state, checked while rst_n is low.
    rst_n = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    id_stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    #3;
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_inst_out", {13'h0, inst_out}, 32'h0);
    chk("rst_inst_pc", {24'h0, inst_pc}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic stream from reset release.
    for (int i = 0; i < 7; i++) begin
      set_in(vecs[i].gnt, vecs[i].rv, vecs[i].rd, 1'b0, 1'b0, 8'h00);
      chk($sformatf("vec%0d_req", i), {31'h0, imem_req}, {31'h0, vecs[i].req_e});
      if (vecs[i].req_e)
        chk($sformatf("vec%0d_addr", i), {24'h0, imem_addr}, {24'h0, vecs[i].addr_e});
      chk($sformatf("vec%0d_valid", i), {31'h0, inst_valid}, {31'h0, vecs[i].valid_e});
      if (vecs[i].chk_inst) begin
        chk($sformatf("vec%0d_pc", i), {24'h0, inst_pc}, {24'h0, vecs[i].ipc_e});
        chk($sformatf("vec%0d_out", i), {13'h0, inst_out}, {13'h0, vecs[i].iout_e});
      end
    end

    // Stall: output holds, requests stop once both slots are committed, stream stays gapless.
    do_reset();
    pend_v = 1'b0; pend_a = '0; exp_pc = 8'h00; consumed = 0;
    repeat (6) stream_cycle(1'b0);
    stream_cycle(1'b1);
    chk("stall_valid0", {31'h0, inst_valid}, 32'h1);
    hold_pc = inst_pc;
    hold_out = inst_out;
    for (int i = 0; i < 3; i++) begin
      stream_cycle(1'b1);
      chk("stall_valid", {31'h0, inst_valid}, 32'h1);
      chk("stall_hold_pc", {24'h0, inst_pc}, {24'h0, hold_pc});
      chk("stall_hold_out", {13'h0, inst_out}, {13'h0, hold_out});
    end
    chk("stall_req_drop", {31'h0, imem_req}, 32'h0);
    repeat (12) stream_cycle(1'b0);
    chk("stream_count", {31'h0, consumed >= 9}, 32'h1);

    // Redirect with two requests (pc 5, 6) in flight.
    do_reset();
    set_in(1'b0, 1'b0, 19'h0, 1'b0, 1'b1, 8'h05);
    chk("rdr_req_blocked", {31'h0, imem_req}, 32'h0);
    set_in(1'b1, 1'b0, 19'h0, 1'b0, 1'b0, 8'h00);
    chk("rdr_addr5", {23'h0, imem_req, imem_addr}, {23'h0, 1'b1, 8'h05});
    set_in(1'b1, 1'b0, 19'h0, 1'b0, 1'b0, 8'h00);
    chk("rdr_addr6", {23'h0, imem_req, imem_addr}, {23'h0, 1'b1, 8'h06});
    set_in(1'b1, 1'b0, 19'h0, 1'b0, 1'b1, 8'h40);
    chk("rdr_req_full", {31'h0, imem_req}, 32'h0);
    set_in(1'b1, 1'b1, 19'h11111, 1'b0, 1'b0, 8'h00);
    chk("rdr_drop1_req", {31'h0, imem_req}, 32'h0);
    chk("rdr_drop1_valid", {31'h0, inst_valid}, 32'h0);
    set_in(1'b1, 1'b1, 19'h22222, 1'b0, 1'b0, 8'h00);
    chk("rdr_new_req", {23'h0, imem_req, imem_addr}, {23'h0, 1'b1, 8'h40});
    chk("rdr_drop2_valid", {31'h0, inst_valid}, 32'h0);
    set_in(1'b0, 1'b1, 19'h33333, 1'b0, 1'b0, 8'h00);
    chk("rdr_pending_valid", {31'h0, inst_valid}, 32'h0);
    set_in(1'b0, 1'b0, 19'h0, 1'b0, 1'b0, 8'h00);
    chk("rdr_first_valid", {31'h0, inst_valid}, 32'h1);
    chk("rdr_first_pc", {24'h0, inst_pc}, 32'h40);
    chk("rdr_first_out", {13'h0, inst_out}, 32'h33333);

    // Redirect coinciding with the only outstanding response.
    set_in(1'b1, 1'b0, 19'h0, 1'b0, 1'b0, 8'h00);
    chk("rdr2_addr", {23'h0, imem_req, imem_addr}, {23'h0, 1'b1, 8'h41});
    set_in(1'b0, 1'b1, 19'h44444, 1'b0, 1'b1, 8'h10);
    set_in(1'b0, 1'b0, 19'h0, 1'b0, 1'b0, 8'h00);
    chk("rdr2_no_stale", {31'h0, inst_valid}, 32'h0);
    chk("rdr2_req", {23'h0, imem_req, imem_addr}, {23'h0, 1'b1, 8'h10});
    set_in(1'b1, 1'b0, 19'h0, 1'b0, 1'b0, 8'h00);
    set_in(1'b0, 1'b1, 19'h55555, 1'b0, 1'b0, 8'h00);
    chk("rdr2_wait_valid", {31'h0, inst_valid}, 32'h0);
    set_in(1'b0, 1'b0, 19'h0, 1'b0, 1'b0, 8'h00);
    chk("rdr2_kept_valid", {31'h0, inst_valid}, 32'h1);
    chk("rdr2_kept_pc", {24'h0, inst_pc}, 32'h10);
    chk("rdr2_kept_out", {13'h0, inst_out}, 32'h55555);

    // PC wrap.
    set_in(1'b0, 1'b0, 19'h0, 1'b0, 1'b1, 8'hFF);
    set_in(1'b1, 1'b0, 19'h0, 1'b0, 1'b0, 8'h00);
    chk("wrap_ff", {23'h0, imem_req, imem_addr}, {23'h0, 1'b1, 8'hFF});
    set_in(1'b0, 1'b0, 19'h0, 1'b0, 1'b0, 8'h00);
    chk("wrap_00", {23'h0, imem_req, imem_addr}, {23'h0, 1'b1, 8'h00});

    // Asynchronous reset with the FIFO full, then restart.
    do_reset();
    set_in(1'b1, 1'b0, 19'h0, 1'b1, 1'b0, 8'h00);
    set_in(1'b1, 1'b1, f(8'h00), 1'b1, 1'b0, 8'h00);
    set_in(1'b0, 1'b1, f(8'h01), 1'b1, 1'b0, 8'h00);
    chk("full_req", {31'h0, imem_req}, 32'h0);
    set_in(1'b0, 1'b0, 19'h0, 1'b1, 1'b0, 8'h00);
    chk("full_valid", {31'h0, inst_valid}, 32'h1);
    chk("full_req2", {31'h0, imem_req}, 32'h0);
    chk("full_head", {24'h0, inst_pc}, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'h0, inst_valid}, 32'h0);
    chk("arst_req", {31'h0, imem_req}, 32'h0);
    chk("arst_out", {13'h0, inst_out}, 32'h0);
    chk("arst_pc", {24'h0, inst_pc}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    set_in(1'b0, 1'b1, 19'h7FFFF, 1'b0, 1'b0, 8'h00);
    chk("restart_req", {23'h0, imem_req, imem_addr}, {23'h0, 1'b1, 8'h00});
    set_in(1'b0, 1'b0, 19'h0, 1'b0, 1'b0, 8'h00);
    chk("stray_rsp_ignored", {31'h0, inst_valid}, 32'h0);
    chk("restart_req2", {23'h0, imem_req, imem_addr}, {23'h0, 1'b1, 8'h00});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
